// File: rtl/char_rom_arbiter.sv
// char_rom_arbiter: round-robin sharing of one 1-cycle-latency glyph ROM port,
// with single-row fetches and 8-row burst prefill, responses tagged by id and row.
module char_rom_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ-1:0]   req_burst,
   input  logic [NUM_REQ*8-1:0] req_char_code,
   input  logic [NUM_REQ*3-1:0] req_row,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [7:0]           rom_char_code,
   output logic [2:0]           rom_row,
   input  logic [7:0]           rom_pixels,
   output logic [NUM_REQ-1:0]   rsp_valid,
   output logic [ID_W-1:0]      rsp_id,
   output logic [2:0]           rsp_row,
   output logic [7:0]           rsp_pixels
);
   typedef enum logic {ARB, BURST} state_t;
   state_t state_q, state_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d, b_id_q, b_id_d, rsp_id_q, rsp_id_d, gnt, cand;
   logic [2:0] cnt_q, cnt_d, rsp_row_q, rsp_row_d, g_row;
   logic [7:0] b_code_q, b_code_d, g_code;
   logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
   logic found, g_burst;
   // Winner search starts at rr_ptr and wraps around the requester ring.
   always_comb begin
      found = 1'b0;
      gnt = '0;
      cand = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            gnt = cand;
         end
      end
      g_code = '0;
      g_row = '0;
      g_burst = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt == ID_W'(i)) begin
            g_code = req_char_code[8*i +: 8];
            g_row = req_row[3*i +: 3];
            g_burst = req_burst[i];
         end
      end
   end
   always_comb begin
      state_d = state_q;
      rr_ptr_d = rr_ptr_q;
      cnt_d = cnt_q;
      b_code_d = b_code_q;
      b_id_d = b_id_q;
      rsp_valid_d = '0;
      rsp_id_d = rsp_id_q;
      rsp_row_d = rsp_row_q;
      req_ready = '0;
      rom_char_code = '0;
      rom_row = '0;
      if (state_q == BURST) begin
         rom_char_code = b_code_q;
         rom_row = cnt_q;
         rsp_valid_d[b_id_q] = 1'b1;
         rsp_id_d = b_id_q;
         rsp_row_d = cnt_q;
         cnt_d = cnt_q + 3'd1;
         state_d = (cnt_q == 3'd7) ? ARB : BURST;
      end else if (found) begin
         req_ready[gnt] = 1'b1;
         rom_char_code = g_code;
         rom_row = g_burst ? 3'd0 : g_row;
         rr_ptr_d = (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
         rsp_valid_d[gnt] = 1'b1;
         rsp_id_d = gnt;
         rsp_row_d = rom_row;
         if (g_burst) begin
            state_d = BURST;
            b_code_d = g_code;
            b_id_d = gnt;
            cnt_d = 3'd1;
         end
      end
      if (reset) begin
         req_ready = '0;
         rom_char_code = '0;
         rom_row = '0;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ARB;
         rr_ptr_q <= '0;
         cnt_q <= '0;
         b_code_q <= '0;
         b_id_q <= '0;
         rsp_valid_q <= '0;
         rsp_id_q <= '0;
         rsp_row_q <= '0;
      end else begin
         state_q <= state_d;
         rr_ptr_q <= rr_ptr_d;
         cnt_q <= cnt_d;
         b_code_q <= b_code_d;
         b_id_q <= b_id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q <= rsp_id_d;
         rsp_row_q <= rsp_row_d;
      end
   end
   assign rsp_valid = rsp_valid_q;
   assign rsp_id = rsp_id_q;
   assign rsp_row = rsp_row_q;
   assign rsp_pixels = rom_pixels;
endmodule

// File: tb/tb_char_rom_arbiter.sv
// tb_char_rom_arbiter: directed and random requests checked against a
// queue-based arbitration model, with a behavioural 1-cycle glyph ROM.
module tb_char_rom_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [3:0] req_valid = '0, req_burst = '0, req_ready, rsp_valid;
   logic [31:0] req_char_code = '0;
   logic [11:0] req_row = '0;
   logic [7:0] rom_char_code, rom_pixels, rsp_pixels;
   logic [2:0] rom_row, rsp_row;
   logic [1:0] rsp_id;
   char_rom_arbiter #(.NUM_REQ(4)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_burst(req_burst),
      .req_char_code(req_char_code), .req_row(req_row), .req_ready(req_ready),
      .rom_char_code(rom_char_code), .rom_row(rom_row), .rom_pixels(rom_pixels),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_row(rsp_row), .rsp_pixels(rsp_pixels)
   );
   initial forever #5 clk = ~clk;
   function automatic logic [7:0] rom_f(logic [9:0] a);
      return a[7:0] ^ {a[9:8], a[9:4]} ^ 8'h5A;
   endfunction
   always @(posedge clk) rom_pixels <= rom_f({rom_char_code[6:0], rom_row});
   typedef struct {int id; logic [7:0] code; logic [2:0] row;} iss_t;
   iss_t bq[$];
   logic [3:0] v = '0, b = '0;
   logic [7:0] code [4];
   logic [2:0] row [4];
   int rr = 0, last_g = -1, pid = 0, vectors = 0, errors = 0;
   bit pv = 0, fresh = 0;
   logic [2:0] prow;
   logic [7:0] ppix;
   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic step(bit rst);
      logic [3:0] er;
      logic [7:0] ec;
      logic [2:0] erow;
      bit iss;
      int id;
      iss_t e;
      @(negedge clk);
      reset = rst;
      req_valid = v;
      req_burst = b;
      for (int i = 0; i < 4; i++) begin
         req_char_code[8*i +: 8] = code[i];
         req_row[3*i +: 3] = row[i];
      end
      #1;
      er = '0; ec = '0; erow = '0; iss = 0; id = 0; last_g = -1;
      if (!rst) begin
         if (bq.size() > 0) begin
            e = bq.pop_front();
            iss = 1; id = e.id; ec = e.code; erow = e.row;
         end else begin
            for (int k = 0; k < 4; k++) begin
               int j;
               j = (rr + k) % 4;
               if (!iss && v[j]) begin
                  iss = 1; id = j; last_g = j; er[j] = 1'b1;
                  ec = code[j];
                  erow = b[j] ? 3'd0 : row[j];
                  rr = (j + 1) % 4;
                  if (b[j]) for (int r = 1; r < 8; r++) bq.push_back('{j, code[j], 3'(r)});
                  v[j] = 1'b0;
               end
            end
         end
      end
      check("req_ready", 32'(req_ready), 32'(er));
      check("rom_char_code", 32'(rom_char_code), 32'(ec));
      check("rom_row", 32'(rom_row), 32'(erow));
      check("rsp_valid", 32'(rsp_valid), pv ? (32'd1 << pid) : 32'd0);
      if (pv) begin
         check("rsp_id", 32'(rsp_id), 32'(pid));
         check("rsp_row", 32'(rsp_row), 32'(prow));
         check("rsp_pixels", 32'(rsp_pixels), 32'(ppix));
      end else if (fresh) begin
         check("rsp_id_reset", 32'(rsp_id), 32'd0);
         check("rsp_row_reset", 32'(rsp_row), 32'd0);
      end
      fresh = rst;
      if (rst) begin
         rr = 0; bq.delete(); pv = 0;
      end else begin
         pv = iss; pid = id; prow = erow; ppix = rom_f({ec[6:0], erow});
      end
   endtask
   task automatic req(int i, logic bu, logic [7:0] c, logic [2:0] r);
      v[i] = 1'b1; b[i] = bu; code[i] = c; row[i] = r;
   endtask
   initial begin
      for (int i = 0; i < 4; i++) begin code[i] = '0; row[i] = '0; end
      step(1); step(1);
      req(0, 0, 8'h41, 3'd3);
      step(0);
      check("first_grant", 32'(last_g), 32'd0);
      check("first_rom_addr", 32'(rom_f({rom_char_code[6:0], rom_row})), 32'(rom_f(10'h20B)));
      step(0);
      for (int n = 0; n < 8; n++) begin
         for (int i = 0; i < 4; i++) req(i, 0, 8'(8'h60 + 8'(n * 4 + i)), 3'(n + i));
         step(0);
         check("rr_continuous", 32'(last_g), 32'((n + 1) % 4));
      end
      v = '0; b = '0;
      req(1, 0, 8'h31, 3'd5);
      step(0);
      req(1, 0, 8'h32, 3'd6);
      req(2, 1, 8'h30, 3'd2);
      step(0);
      check("burst_grant", 32'(last_g), 32'd2);
      for (int n = 0; n < 7; n++) step(0);
      step(0);
      check("after_burst_grant", 32'(last_g), 32'd1);
      req(2, 0, 8'h22, 3'd1);
      step(0);
      req(3, 0, 8'hC3, 3'd7);
      req(0, 0, 8'h80, 3'd0);
      step(0);
      check("wrap_first", 32'(last_g), 32'd3);
      step(0);
      check("wrap_second", 32'(last_g), 32'd0);
      req(0, 1, 8'h7F, 3'd5);
      step(0);
      step(0); step(0); step(0);
      step(1);
      req(1, 0, 8'h11, 3'd2);
      req(2, 0, 8'h12, 3'd3);
      step(0);
      check("post_reset_grant", 32'(last_g), 32'd1);
      step(0);
      for (int n = 0; n < 10; n++) step(0);
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 4; i++)
            if (!v[i] && $urandom_range(2) == 0)
               req(i, $urandom_range(5) == 0, 8'($urandom), 3'($urandom));
         step($urandom_range(60) == 0);
      end
      v = '0;
      for (int n = 0; n < 10; n++) step(0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/char_rom_arbiter.md
Name: char_rom_arbiter

Overview:
- Shares one 8x8 glyph ROM port, with 1-cycle synchronous read latency, between NUM_REQ text-rendering requesters, e.g. score overlay, status banner and countdown.
- Grants one requester per cycle in round-robin order and drives the ROM address.
- Routes the returned bitmap row back to the granted requester, tagged with requester id and row.
- Optional burst mode fetches all 8 rows of one glyph back-to-back for line-buffer prefill.

Parameters:
- NUM_REQ, 4, number of requesters (legal 2..8).
- ID_W, $clog2(NUM_REQ), requester id width (derived; not overridden).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_burst  in  NUM_REQ  1 = fetch rows 0..7 of the glyph; 0 = single row.
- req_char_code  in  NUM_REQ*8  packed char codes; requester i occupies [8i+7:8i].
- req_row  in  NUM_REQ*3  packed row indices; ignored when req_burst=1.
- req_ready  out  NUM_REQ  one-hot grant; handshake = valid & ready.
- rom_char_code  out  8  ROM char code.
- rom_row  out  3  ROM row.
- rom_pixels  in  8  ROM data, valid 1 cycle after the address is presented.
- rsp_valid  out  NUM_REQ  one-hot response strobe.
- rsp_id  out  ID_W  requester that owns rsp_pixels.
- rsp_row  out  3  row index of rsp_pixels.
- rsp_pixels  out  8  bitmap row, equal to rom_pixels; meaningful only when any rsp_valid is set.

Behaviour:
- States: ARB, BURST.
- Reset values: state ARB, rr_ptr 0, burst counter 0, rsp_valid 0, rsp_id 0, rsp_row 0.
- While reset=1, req_ready=0 and rom_char_code/rom_row=0.
- ARB winner selection: combinational. Search index rr_ptr, rr_ptr+1, ... mod NUM_REQ; the first with req_valid=1 wins. req_ready = one-hot of the winner, in the same cycle. No valid requester: req_ready=0 and ROM address=0.
- ARB handshake with winner g:
  - rom_char_code = req_char_code[g].
  - rom_row = req_row[g] if single, else 0.
  - rr_ptr <= (g+1) mod NUM_REQ.
  - Register the response pipeline: rsp_valid[g], rsp_id=g, rsp_row = the issued row.
- Single latency: handshake at cycle t -> rsp_valid[g]=1 at t+1, with rsp_pixels = glyph row. Back-to-back single handshakes give one response per cycle.
- Burst entry: handshake with req_burst[g]=1 latches the code and g, sets counter to 1, and moves to BURST.
- BURST:
  - All req_ready=0.
  - Each cycle issues the latched code with row=counter and pipelines a response for g; counter increments.
  - When counter=7 is issued, return to ARB next cycle.
  - Burst at cycle t gives rsp_valid[g] on t+1..t+8, rows 0..7 in order. The next handshake can occur at t+8.
- Requester obligations: req_valid, char code, row and burst must hold stable until the handshake. The arbiter never grants a non-valid requester.
- char_code bit 7 is passed through unchanged; the ROM ignores it.
- Simultaneous requests: only the winner is granted; the others keep waiting. Round-robin guarantees each valid requester a grant within NUM_REQ handshakes.
- Reset mid-burst or with a response in flight: burst aborts; rsp_valid=0 in the cycle after reset; no stale response is emitted.
- rr_ptr wrap: from NUM_REQ-1 it goes to 0.

Test Plan:
- Reset, then req0 single code 0x41 row 3 at cycle t -> req_ready=0001 at t; rom addr {0x41,3}; rsp_valid=0001, rsp_id=0, rsp_row=3, rsp_pixels = MIF byte at address 0x20B at t+1.
- All 4 requesters valid-single continuously -> grants cycle 0,1,2,3,0,...; exactly one rsp_valid bit per cycle, each matching the id issued one cycle earlier.
- req2 burst code 0x30 while req1 valid -> req2 granted; req_ready all 0 for the next 7 cycles; rsp rows 0..7 for id 2 on 8 consecutive cycles; req1 granted at t+8.
- rr_ptr=3 with req3 and req0 valid -> req3 granted first, then req0; rr_ptr wraps to 0, then to 1.
- reset asserted at burst row 4 -> rsp_valid=0 from the cycle after reset; state ARB; the first post-reset grant goes to the lowest-index valid requester (rr_ptr=0).
- No req_valid for 10 cycles -> req_ready=0, rsp_valid=0, ROM address=0 throughout.
